// File: rtl/multicycle_main_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/writeback, drives datapath
// selects and strobes, with optional memory wait handshake, illegal trap and retire counter.
module multicycle_main_fsm #(
  parameter bit          MEM_WAIT = 1'b0,
  parameter bit          EN_ITYPE = 1'b1,
  parameter bit          EN_JAL   = 1'b1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             memReady,
  output logic             pcUpdate,
  output logic             branch,
  output logic             regWrite,
  output logic             memWrite,
  output logic             irWrite,
  output logic             adrSrc,
  output logic [1:0]       resultSrc,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       immSrc,
  output logic             memReq,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire_c;
  logic             mem_done_c;

  // Without the wait handshake every memory access finishes in its first cycle.
  assign mem_done_c = memReady | ~MEM_WAIT;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_c) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    retire_c  = 1'b0;
    pcUpdate  = 1'b0;
    branch    = 1'b0;
    regWrite  = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    adrSrc    = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    memReq    = 1'b0;
    illegal   = 1'b0;
    immSrc    = 2'b00;

    case (state_q)
      S_FETCH: begin
        irWrite   = mem_done_c;
        pcUpdate  = mem_done_c;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        memReq    = 1'b1;
        if (mem_done_c) state_d = S_DECODE;
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = EN_ITYPE ? S_EXECI : S_TRAP;
          OP_JAL:       state_d = EN_JAL ? S_JAL : S_TRAP;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrSrc = 1'b1;
        memReq = 1'b1;
        if (mem_done_c) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        state_d   = S_FETCH;
        retire_c  = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = mem_done_c;
        memReq   = 1'b1;
        if (mem_done_c) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end
      S_EXECR: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_BEQ: begin
        aluSrcA  = 2'b10;
        aluOp    = 2'b01;
        branch   = 1'b1;
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_JAL: begin
        aluSrcA  = 2'b01;
        aluSrcB  = 2'b10;
        pcUpdate = 1'b1;
        state_d  = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset silences every strobe and parks the selects at their fetch values.
    if (reset) begin
      pcUpdate  = 1'b0;
      branch    = 1'b0;
      regWrite  = 1'b0;
      memWrite  = 1'b0;
      irWrite   = 1'b0;
      memReq    = 1'b0;
      illegal   = 1'b0;
      adrSrc    = 1'b0;
      resultSrc = 2'b10;
      aluSrcA   = 2'b00;
      aluSrcB   = 2'b10;
      aluOp     = 2'b00;
    end

    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BEQ:  immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

  assign state   = 4'(state_q);
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: two configurations driven in turn, every cycle compared
// against an instruction-level model (state path per opcode class, output table, retire count).
module tb_multicycle_main_fsm;

  localparam int unsigned NDUT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_s [NDUT];
  logic [6:0] op_s    [NDUT];
  logic       rdy_s   [NDUT];
  logic       pc_s    [NDUT];
  logic       br_s    [NDUT];
  logic       rw_s    [NDUT];
  logic       mw_s    [NDUT];
  logic       ir_s    [NDUT];
  logic       adr_s   [NDUT];
  logic       mq_s    [NDUT];
  logic       ill_s   [NDUT];
  logic [1:0] rs_s    [NDUT];
  logic [1:0] sa_s    [NDUT];
  logic [1:0] sb_s    [NDUT];
  logic [1:0] ao_s    [NDUT];
  logic [1:0] im_s    [NDUT];
  logic [3:0] st_s    [NDUT];
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  // dut 0: defaults; dut 1: memory wait, I-type and jal disabled, 4-bit counter
  multicycle_main_fsm u_a (
    .clk(clk), .reset(reset_s[0]), .op(op_s[0]), .memReady(rdy_s[0]),
    .pcUpdate(pc_s[0]), .branch(br_s[0]), .regWrite(rw_s[0]), .memWrite(mw_s[0]),
    .irWrite(ir_s[0]), .adrSrc(adr_s[0]), .resultSrc(rs_s[0]), .aluSrcA(sa_s[0]),
    .aluSrcB(sb_s[0]), .aluOp(ao_s[0]), .immSrc(im_s[0]), .memReq(mq_s[0]),
    .illegal(ill_s[0]), .state(st_s[0]), .instret(cnt_a)
  );

  multicycle_main_fsm #(.MEM_WAIT(1'b1), .EN_ITYPE(1'b0), .EN_JAL(1'b0), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset_s[1]), .op(op_s[1]), .memReady(rdy_s[1]),
    .pcUpdate(pc_s[1]), .branch(br_s[1]), .regWrite(rw_s[1]), .memWrite(mw_s[1]),
    .irWrite(ir_s[1]), .adrSrc(adr_s[1]), .resultSrc(rs_s[1]), .aluSrcA(sa_s[1]),
    .aluSrcB(sb_s[1]), .aluOp(ao_s[1]), .immSrc(im_s[1]), .memReq(mq_s[1]),
    .illegal(ill_s[1]), .state(st_s[1]), .instret(cnt_b)
  );

  bit          cfg_wait [NDUT] = '{1'b0, 1'b1};
  bit          cfg_en   [NDUT] = '{1'b1, 1'b0};
  logic [31:0] cfg_mask [NDUT] = '{32'hFFFF_FFFF, 32'h0000_000F};

  logic [31:0] exp_cnt [NDUT];
  int          path_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  localparam logic [6:0] LW = 7'h03, SW = 7'h23, RT = 7'h33, IT = 7'h13, JL = 7'h6F, BQ = 7'h63;

  task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s dut%0d: got %h expected %h", tag, d, obs, exp);
  endtask

  // {pcUpdate,branch,regWrite,memWrite,irWrite,adrSrc,memReq,illegal,resultSrc,aluSrcA,aluSrcB,aluOp}
  function automatic logic [15:0] exp_out(input int s, input logic r, input logic rst);
    if (rst) return {8'b0, 2'b10, 2'b00, 2'b10, 2'b00};
    case (s)
      0:  return {r, 1'b0, 1'b0, 1'b0, r, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
      1:  return {8'b0, 2'b00, 2'b01, 2'b01, 2'b00};
      2:  return {8'b0, 2'b00, 2'b10, 2'b01, 2'b00};
      3:  return {5'b0, 1'b1, 1'b1, 1'b0, 8'b0};
      4:  return {2'b0, 1'b1, 5'b0, 2'b01, 6'b0};
      5:  return {3'b0, r, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0};
      6:  return {8'b0, 2'b00, 2'b10, 2'b00, 2'b10};
      7:  return {2'b0, 1'b1, 5'b0, 8'b0};
      8:  return {8'b0, 2'b00, 2'b10, 2'b01, 2'b10};
      9:  return {1'b1, 7'b0, 2'b00, 2'b01, 2'b10, 2'b00};
      10: return {1'b0, 1'b1, 6'b0, 2'b00, 2'b10, 2'b00, 2'b01};
      default: return {7'b0, 1'b1, 8'b0};
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [15:0] obs_out(input int d);
    return {pc_s[d], br_s[d], rw_s[d], mw_s[d], ir_s[d], adr_s[d], mq_s[d], ill_s[d],
            rs_s[d], sa_s[d], sb_s[d], ao_s[d]};
  endfunction

  task automatic build_path(input int d, input logic [6:0] o);
    path_q = '{0, 1};
    if (o == LW)                       path_q = '{0, 1, 2, 3, 4};
    else if (o == SW)                  path_q = '{0, 1, 2, 5};
    else if (o == RT)                  path_q = '{0, 1, 6, 7};
    else if (o == IT && cfg_en[d])     path_q = '{0, 1, 8, 7};
    else if (o == JL && cfg_en[d])     path_q = '{0, 1, 9, 7};
    else if (o == BQ)                  path_q = '{0, 1, 10};
    else                               path_q.push_back(11);
  endtask

  // One clock: drive inputs after the edge, compare at the falling edge. s < 0 skips state/count.
  task automatic cycle(input int d, input int s, input logic [6:0] o, input logic r, input logic rst);
    logic [31:0] cnt_obs;
    op_s[d]    = (s == 1 || s == 2) ? o : 7'($urandom);
    rdy_s[d]   = r;
    reset_s[d] = rst;
    @(negedge clk);
    cnt_obs = (d == 0) ? cnt_a : 32'(cnt_b);
    chk(d, $sformatf("outs s%0d", s), 32'(obs_out(d)), 32'(exp_out(s, r | ~cfg_wait[d], rst)));
    chk(d, "immSrc", 32'(im_s[d]), 32'(exp_imm(op_s[d])));
    if (s >= 0) begin
      chk(d, "state", 32'(st_s[d]), 32'(s));
      chk(d, "instret", cnt_obs, exp_cnt[d]);
    end
    @(posedge clk);
    #1;
  endtask

  // waits < 0: random stall count per memory state
  task automatic run_instr(input int d, input logic [6:0] o, input int waits);
    int nw;
    build_path(d, o);
    foreach (path_q[i]) begin
      nw = 0;
      if (cfg_wait[d] && (path_q[i] == 0 || path_q[i] == 3 || path_q[i] == 5))
        nw = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
      for (int k = 0; k < nw; k++) cycle(d, path_q[i], o, 1'b0, 1'b0);
      cycle(d, path_q[i], o, cfg_wait[d] ? 1'b1 : 1'($urandom), 1'b0);
    end
    if (path_q[path_q.size()-1] != 11) exp_cnt[d] = (exp_cnt[d] + 32'd1) & cfg_mask[d];
  endtask

  task automatic do_reset(input int d);
    exp_cnt[d] = 32'd0;
    cycle(d, -1, 7'h00, 1'b0, 1'b1);
    cycle(d, 0, 7'h00, 1'b0, 1'b1);
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] o;
    case ($urandom_range(0, 6))
      0: o = LW;
      1: o = SW;
      2: o = RT;
      3: o = IT;
      4: o = JL;
      5: o = BQ;
      default: begin
        o = 7'($urandom);
        if (o inside {LW, SW, RT, IT, JL, BQ}) o = 7'h7F;
      end
    endcase
    return o;
  endfunction

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      reset_s[d] = 1'b1;
      op_s[d]    = 7'h00;
      rdy_s[d]   = 1'b0;
      exp_cnt[d] = 32'd0;
    end
    #1;

    // Default configuration: one of each class, then random traffic.
    do_reset(0);
    run_instr(0, RT, 0);
    run_instr(0, LW, 0);
    run_instr(0, SW, 0);
    run_instr(0, 7'h7F, 0);
    run_instr(0, IT, 0);
    run_instr(0, JL, 0);
    run_instr(0, BQ, 0);
    for (int n = 0; n < 40; n++) run_instr(0, pick_op(), 0);

    // Reset landing in MEMREAD of a load aborts it and clears the counter.
    build_path(0, LW);
    cycle(0, 0, LW, 1'b1, 1'b0);
    cycle(0, 1, LW, 1'b1, 1'b0);
    cycle(0, 2, LW, 1'b1, 1'b0);
    cycle(0, 3, LW, 1'b1, 1'b1);
    exp_cnt[0] = 32'd0;
    run_instr(0, RT, 0);
    reset_s[0] = 1'b1;

    // Wait-handshake configuration with I-type and jal disabled.
    do_reset(1);
    run_instr(1, IT, 0);
    run_instr(1, JL, 0);
    run_instr(1, 7'h7F, 0);
    run_instr(1, LW, 3);
    run_instr(1, SW, 2);
    for (int n = 0; n < 16; n++) run_instr(1, BQ, -1);
    for (int n = 0; n < 40; n++) run_instr(1, pick_op(), -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_main_fsm.md
# multicycle_main_fsm

Control FSM for the multicycle RV32I core, successor of the single-cycle main decoder. Decodes `op` once per instruction and sequences FETCH/DECODE/EXECUTE/WRITEBACK over several cycles, driving datapath selects and write strobes. Adds an optional memory ready handshake, compile-time enables for I-type ALU and `jal`, an illegal-opcode trap pulse and a retired-instruction counter. Sits between the instruction register and the multicycle datapath; `aluOp` feeds the existing ALU decoder unchanged.

## Interface
- `MEM_WAIT`, default 0: 0 = memory completes in one cycle and `memReady` is ignored; 1 = memory states hold until `memReady`=1.
- `EN_ITYPE`, default 1: 1 = opcode 0010011 supported; 0 = treated as illegal.
- `EN_JAL`, default 1: 1 = opcode 1101111 supported; 0 = treated as illegal.
- `CNT_W`, default 32: width of `instret`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7: opcode from the instruction register, sampled in DECODE.
- `memReady` in 1: memory access complete (used only when `MEM_WAIT`=1).
- `pcUpdate`, `branch`, `regWrite`, `memWrite`, `irWrite`, `adrSrc` out 1 each: datapath strobes and selects.
- `resultSrc`, `aluSrcA`, `aluSrcB`, `aluOp`, `immSrc` out 2 each: datapath selects.
- `memReq` out 1: memory access in progress (FETCH, MEMREAD, MEMWRITE).
- `illegal` out 1: one-cycle trap pulse.
- `state` out 4: current state, for debug.
- `instret` out `CNT_W`: count of retired instructions.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, TRAP=11. Codes 12-15 go to FETCH.
- Outputs are Moore, decoded from `state`. Any output not listed for a state is 0.
  - FETCH: `adrSrc`=0, `irWrite`=1, `aluSrcA`=00, `aluSrcB`=10, `aluOp`=00, `resultSrc`=10, `pcUpdate`=1, `memReq`=1.
  - DECODE: `aluSrcA`=01, `aluSrcB`=01, `aluOp`=00.
  - MEMADR: `aluSrcA`=10, `aluSrcB`=01.
  - MEMREAD: `adrSrc`=1, `memReq`=1.
  - MEMWB: `resultSrc`=01, `regWrite`=1.
  - MEMWRITE: `adrSrc`=1, `memWrite`=1, `memReq`=1.
  - EXECR: `aluSrcA`=10, `aluOp`=10.
  - EXECI: `aluSrcA`=10, `aluSrcB`=01, `aluOp`=10.
  - ALUWB: `regWrite`=1.
  - BEQ: `aluSrcA`=10, `aluOp`=01, `branch`=1.
  - JAL: `aluSrcA`=01, `aluSrcB`=10, `pcUpdate`=1.
  - TRAP: `illegal`=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE, by `op`:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI if `EN_ITYPE`, else TRAP.
    - 1101111 → JAL if `EN_JAL`, else TRAP.
    - 1100011 → BEQ.
    - anything else → TRAP.
  - MEMADR→MEMREAD if `op`=0000011, else MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECR/EXECI/JAL→ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ, TRAP → FETCH.
- `immSrc` is combinational from `op`, independent of state: 0100011→01, 1100011→10, 1101111→11, all others 00.
- `MEM_WAIT`=1:
  - FETCH, MEMREAD and MEMWRITE hold while `memReady`=0.
  - `irWrite`, `pcUpdate` (in FETCH) and `memWrite` are asserted only in the cycle where `memReady`=1; the state advances on that edge.
  - `memReq` stays high for the whole wait.
- `instret`:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Does not increment on TRAP→FETCH.
  - Wraps from 2^`CNT_W`-1 to 0.

## Timing
- Reset:
  - While `reset`=1, all strobes (`pcUpdate`, `branch`, `regWrite`, `memWrite`, `irWrite`, `memReq`, `illegal`) are forced to 0. Selects show their FETCH values.
  - The first edge with `reset`=1 sets `state`=0 and `instret`=0.
  - Reset asserted mid-instruction aborts it: no further strobes, no `instret` increment.
- Latency with `MEM_WAIT`=0, FETCH to FETCH: `lw` 5, `sw` 4, R-type 4, I-type 4, `jal` 4, `beq` 3, illegal 3.
- With `MEM_WAIT`=1, each memory state adds N cycles, where N = cycles with `memReady`=0.
- `illegal` is high for exactly one cycle per illegal opcode.
- `op` may change in any cycle other than DECODE and MEMADR; only values in those states affect the path taken.

## Test plan
- Reset, then R-type `op`=0110011 with `MEM_WAIT`=0 → states 0,1,6,7,0; `regWrite`=1 only in state 7; `aluOp`=10 in state 6; `instret`=1.
- `lw` then `sw` → states 0,1,2,3,4 then 0,1,2,5; `memWrite` pulses once in state 5; `instret`=2; `immSrc`=01 while `op`=0100011.
- `op`=1111111, and 0010011 with `EN_ITYPE`=0 → DECODE→TRAP, `illegal` one-cycle pulse, no `regWrite`/`memWrite`, `instret` unchanged.
- `MEM_WAIT`=1, `memReady` low for 3 cycles in FETCH → `state` holds at 0 for 4 cycles, `memReq`=1 throughout, `irWrite`/`pcUpdate` high only in the 4th cycle.
- `CNT_W`=4, run 16 `beq` (3 cycles each) → `instret` goes 15→0; `branch`=1 only in state 10; `aluOp`=01.
- `reset` asserted in MEMREAD of a `lw` → next cycle `state`=0, `instret`=0, and `regWrite` never asserted for that `lw`.
